// File: rtl/flags_unit_if.sv
// flags_unit_if: control/data bundle between the datapath and the flag unit.
// Ports: master drives AC_update/opcode/op1/op2/AC_result/flag_ld/flag_din/
//        push/pop/err_clr and observes the flags and stack status;
//        slave is the flag unit's view of the same signals.
interface flags_unit_if #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
);
    logic                         AC_update;
    logic [3:0]                   opcode;
    logic [WIDTH-1:0]             op1;
    logic [WIDTH-1:0]             op2;
    logic [WIDTH-1:0]             AC_result;
    logic                         flag_ld;
    logic [3:0]                   flag_din;
    logic                         push;
    logic                         pop;
    logic                         err_clr;
    logic                         N;
    logic                         Z;
    logic                         C;
    logic                         V;
    logic [$clog2(DEPTH+1)-1:0]   depth_cnt;
    logic                         full;
    logic                         empty;
    logic                         err_ovf;
    logic                         err_unf;

    modport master (
        output AC_update, opcode, op1, op2, AC_result, flag_ld, flag_din, push, pop, err_clr,
        input  N, Z, C, V, depth_cnt, full, empty, err_ovf, err_unf
    );

    modport slave (
        input  AC_update, opcode, op1, op2, AC_result, flag_ld, flag_din, push, pop, err_clr,
        output N, Z, C, V, depth_cnt, full, empty, err_ovf, err_unf
    );
endinterface

// File: rtl/flags_unit.sv
// flags_unit: registered N/Z/C/V condition flags with a LIFO flag stack.
// Ports: clk (rising edge), rst (asynchronous, active-low),
//        bus (flags_unit_if.slave): operands/result/opcode, AC_update,
//        flag_ld/flag_din, push/pop, err_clr in; N/Z/C/V, depth_cnt,
//        full/empty, sticky err_ovf/err_unf out.
module flags_unit #(
    parameter int         WIDTH  = 12,
    parameter int         DEPTH  = 4,
    parameter logic [3:0] OP_ADD = 4'b1001,
    parameter logic [3:0] OP_SUB = 4'b1010,
    parameter logic [3:0] OP_CMP = 4'b0100
) (
    input logic         clk,
    input logic         rst,
    flags_unit_if.slave bus
);
    localparam int DW = $clog2(DEPTH + 1);
    // stack index width, kept at least one bit so DEPTH=1 still elaborates
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [3:0]     flags;
    logic [3:0]     flags_nxt;
    logic [3:0]     arith;
    logic [3:0]     stack [2**AW];
    logic [DW-1:0]  depth;
    logic [WIDTH:0] sum;
    logic           full;
    logic           empty;
    logic           is_add;
    logic           is_sub;
    logic           res_n;
    logic           a_n;
    logic           b_n;
    logic           do_push;
    logic           do_pop;
    logic           ovf_evt;
    logic           unf_evt;

    assign full   = depth == DW'(DEPTH);
    assign empty  = depth == '0;
    assign sum    = {1'b0, bus.op1} + {1'b0, bus.op2};
    assign is_add = bus.opcode == OP_ADD;
    assign is_sub = bus.opcode == OP_SUB || bus.opcode == OP_CMP;
    assign res_n  = bus.AC_result[WIDTH-1];
    assign a_n    = bus.op1[WIDTH-1];
    assign b_n    = bus.op2[WIDTH-1];

    // A simultaneous push and pop cancels out: stack untouched, no error,
    // and the flags are not restored from the stack.
    assign do_push = bus.push & ~bus.pop & ~full;
    assign do_pop  = bus.pop & ~bus.push & ~empty;
    assign ovf_evt = bus.push & ~bus.pop & full;
    assign unf_evt = bus.pop & ~bus.push & empty;

    always_comb begin
        arith = {res_n,
                 bus.AC_result == '0,
                 is_add ? sum[WIDTH] : is_sub ? bus.op1 >= bus.op2 : flags[1],
                 is_add ? (a_n == b_n) & (res_n != a_n) :
                 is_sub ? (a_n != b_n) & (res_n != a_n) : flags[0]};
        flags_nxt = do_pop      ? stack[AW'(depth - 1'b1)] :
                    bus.flag_ld ? bus.flag_din :
                    bus.AC_update ? arith : flags;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flags       <= '0;
            depth       <= '0;
            bus.err_ovf <= 1'b0;
            bus.err_unf <= 1'b0;
        end else begin
            flags       <= flags_nxt;
            depth       <= do_push ? depth + 1'b1 : do_pop ? depth - 1'b1 : depth;
            bus.err_ovf <= (bus.err_ovf & ~bus.err_clr) | ovf_evt;
            bus.err_unf <= (bus.err_unf & ~bus.err_clr) | unf_evt;
        end
    end

    // Stack contents need no reset: depth 0 makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (do_push) stack[AW'(depth)] <= flags;
    end

    assign {bus.N, bus.Z, bus.C, bus.V} = flags;
    assign bus.depth_cnt = depth;
    assign bus.full      = full;
    assign bus.empty     = empty;
endmodule

// File: tb/tb_flags_unit.sv
// tb_flags_unit: directed plus randomized checks of flags_unit at WIDTH 12/8/16
// against a behavioural flag/stack model.
module tb_flags_unit;
    localparam logic [3:0] ADD = 4'b1001;
    localparam logic [3:0] SUB = 4'b1010;
    localparam logic [3:0] CMP = 4'b0100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    flags_unit_if #(.WIDTH(12), .DEPTH(4)) b12 ();
    flags_unit_if #(.WIDTH(8),  .DEPTH(2)) b8 ();
    flags_unit_if #(.WIDTH(16), .DEPTH(2)) b16 ();

    flags_unit #(.WIDTH(12), .DEPTH(4)) u12 (.clk(clk), .rst(rst), .bus(b12.slave));
    flags_unit #(.WIDTH(8),  .DEPTH(2)) u8  (.clk(clk), .rst(rst), .bus(b8.slave));
    flags_unit #(.WIDTH(16), .DEPTH(2)) u16 (.clk(clk), .rst(rst), .bus(b16.slave));

    int checks = 0;
    int errors = 0;
    logic [3:0] m_flags;
    logic [3:0] f8;
    logic [3:0] f16;
    logic       m_ovf;
    logic       m_unf;
    logic [3:0] m_stack[$];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] arith_ref(int w, logic [3:0] opc, longint a, longint b,
                                             longint r, logic [3:0] cur);
        longint m = longint'(1) << w;
        bit n  = r >= m / 2;
        bit z  = r == 0;
        bit an = a >= m / 2;
        bit bn = b >= m / 2;
        if (opc == ADD) return {n, z, a + b >= m, an == bn && n != an};
        if (opc == SUB || opc == CMP) return {n, z, a >= b, an != bn && n != an};
        return {n, z, cur[1:0]};
    endfunction

    function automatic longint rnd_op(int w);
        longint m = longint'(1) << w;
        case ($urandom % 6)
            0: return 0;
            1: return m / 2;
            2: return m / 2 - 1;
            3: return m - 1;
            default: return longint'($urandom) % m;
        endcase
    endfunction

    function automatic longint mk_res(int w, logic [3:0] opc, longint a, longint b);
        longint m = longint'(1) << w;
        if (opc == ADD) return (a + b) % m;
        if (opc == SUB || opc == CMP) return (a - b + m) % m;
        return longint'($urandom) % m;
    endfunction

    function automatic logic [3:0] rnd_opc();
        case ($urandom % 4)
            0: return ADD;
            1: return SUB;
            2: return CMP;
            default: return 4'($urandom);
        endcase
    endfunction

    task automatic idle();
        b12.AC_update = 0; b12.opcode = 0; b12.op1 = 0; b12.op2 = 0; b12.AC_result = 0;
        b12.flag_ld = 0; b12.flag_din = 0; b12.push = 0; b12.pop = 0; b12.err_clr = 0;
        b8.AC_update = 0; b8.opcode = 0; b8.op1 = 0; b8.op2 = 0; b8.AC_result = 0;
        b8.flag_ld = 0; b8.flag_din = 0; b8.push = 0; b8.pop = 0; b8.err_clr = 0;
        b16.AC_update = 0; b16.opcode = 0; b16.op1 = 0; b16.op2 = 0; b16.AC_result = 0;
        b16.flag_ld = 0; b16.flag_din = 0; b16.push = 0; b16.pop = 0; b16.err_clr = 0;
    endtask

    task automatic set12(logic upd, logic [3:0] opc, longint a, longint b, longint r);
        b12.AC_update = upd; b12.opcode = opc;
        b12.op1 = a[11:0]; b12.op2 = b[11:0]; b12.AC_result = r[11:0];
    endtask

    task automatic set8(logic upd, logic [3:0] opc, longint a, longint b, longint r);
        b8.AC_update = upd; b8.opcode = opc;
        b8.op1 = a[7:0]; b8.op2 = b[7:0]; b8.AC_result = r[7:0];
    endtask

    task automatic set16(logic upd, logic [3:0] opc, longint a, longint b, longint r);
        b16.AC_update = upd; b16.opcode = opc;
        b16.op1 = a[15:0]; b16.op2 = b[15:0]; b16.AC_result = r[15:0];
    endtask

    task automatic model_reset();
        m_flags = 0; f8 = 0; f16 = 0; m_ovf = 0; m_unf = 0;
        m_stack.delete();
    endtask

    task automatic model_step();
        bit pu;
        bit po;
        int n;
        logic [3:0] nf;
        pu = b12.push;
        po = b12.pop;
        n  = m_stack.size();
        if (po && !pu && n > 0) nf = m_stack[n-1];
        else if (b12.flag_ld) nf = b12.flag_din;
        else if (b12.AC_update) nf = arith_ref(12, b12.opcode, b12.op1, b12.op2, b12.AC_result, m_flags);
        else nf = m_flags;
        if (pu && !po && n < 4) m_stack.push_back(m_flags);
        if (po && !pu && n > 0) void'(m_stack.pop_back());
        m_ovf = (m_ovf && !b12.err_clr) || (pu && !po && n == 4);
        m_unf = (m_unf && !b12.err_clr) || (po && !pu && n == 0);
        m_flags = nf;
        if (b8.AC_update) f8 = arith_ref(8, b8.opcode, b8.op1, b8.op2, b8.AC_result, f8);
        if (b16.AC_update) f16 = arith_ref(16, b16.opcode, b16.op1, b16.op2, b16.AC_result, f16);
    endtask

    task automatic check_all();
        check("nzcv12", {b12.N, b12.Z, b12.C, b12.V}, m_flags);
        check("depth",  b12.depth_cnt, m_stack.size());
        check("full",   b12.full, m_stack.size() == 4);
        check("empty",  b12.empty, m_stack.size() == 0);
        check("ovf",    b12.err_ovf, m_ovf);
        check("unf",    b12.err_unf, m_unf);
        check("nzcv8",  {b8.N, b8.Z, b8.C, b8.V}, f8);
        check("nzcv16", {b16.N, b16.Z, b16.C, b16.V}, f16);
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ar(logic [3:0] opc, longint a, longint b, longint r, logic [3:0] exp);
        idle();
        set12(1, opc, a, b, r);
        cyc();
        check("arith12", {b12.N, b12.Z, b12.C, b12.V}, exp);
    endtask

    task automatic arw(logic [3:0] opc, longint a8, longint c8, longint r8, logic [3:0] e8,
                       longint a16, longint c16, longint r16, logic [3:0] e16);
        idle();
        set8(1, opc, a8, c8, r8);
        set16(1, opc, a16, c16, r16);
        cyc();
        check("arith8", {b8.N, b8.Z, b8.C, b8.V}, e8);
        check("arith16", {b16.N, b16.Z, b16.C, b16.V}, e16);
    endtask

    task automatic ld(logic [3:0] din, logic pu);
        idle();
        b12.flag_ld = 1; b12.flag_din = din; b12.push = pu;
        cyc();
    endtask

    task automatic check_cleared(string tag);
        check({tag, "_nzcv"}, {b12.N, b12.Z, b12.C, b12.V}, 0);
        check({tag, "_depth"}, b12.depth_cnt, 0);
        check({tag, "_empty"}, b12.empty, 1);
        check({tag, "_full"}, b12.full, 0);
        check({tag, "_ovf"}, b12.err_ovf, 0);
        check({tag, "_unf"}, b12.err_unf, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks %0d errors %0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_pop [4];
        logic [3:0] opc;
        longint a;
        longint b;
        exp_pop[0] = 4'b1000; exp_pop[1] = 4'b0100; exp_pop[2] = 4'b0010; exp_pop[3] = 4'b0001;

        // reset held with every control active
        idle();
        b12.push = 1; b12.pop = 1; b12.flag_ld = 1; b12.flag_din = 4'hf;
        set12(1, ADD, 12'hfff, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        check_cleared("reset");
        model_reset();
        idle();
        rst = 1;

        // arithmetic at WIDTH=12
        ar(ADD, 12'hfff, 12'h001, 12'h000, 4'b0110);
        ar(SUB, 12'h005, 12'h002, 12'h003, 4'b0010);
        ar(ADD, 12'h7ff, 12'h001, 12'h800, 4'b1001);
        ar(SUB, 12'h800, 12'h001, 12'h7ff, 4'b0011);
        ar(CMP, 12'h005, 12'h002, 12'h003, 4'b0010);
        ar(SUB, 12'h800, 12'h001, 12'h7ff, 4'b0011);
        ar(4'b0000, 12'h000, 12'h000, 12'h800, 4'b1011);

        // hold and priority
        idle();
        set12(0, ADD, 12'hfff, 12'h001, 12'h000);
        cyc();
        check("hold", {b12.N, b12.Z, b12.C, b12.V}, 4'b1011);
        idle();
        set12(1, ADD, 12'hfff, 12'h001, 12'h000);
        b12.flag_ld = 1; b12.flag_din = 4'b1010;
        cyc();
        check("ld_prio", {b12.N, b12.Z, b12.C, b12.V}, 4'b1010);

        // arithmetic at WIDTH=8 and WIDTH=16
        arw(ADD, 8'h7f, 8'h01, 8'h80, 4'b1001, 16'h7fff, 16'h0001, 16'h8000, 4'b1001);
        arw(SUB, 8'h80, 8'h01, 8'h7f, 4'b0011, 16'h8000, 16'h0001, 16'h7fff, 4'b0011);
        arw(ADD, 8'hff, 8'h01, 8'h00, 4'b0110, 16'hffff, 16'h0001, 16'h0000, 4'b0110);
        arw(CMP, 8'h01, 8'h02, 8'hff, 4'b1000, 16'h0001, 16'h0002, 16'hffff, 4'b1000);

        // fill the stack, overflow, drain, underflow
        ld(4'b0001, 0);
        ld(4'b0010, 1);
        ld(4'b0100, 1);
        ld(4'b1000, 1);
        ld(4'b1111, 1);
        idle();
        b12.push = 1;
        cyc();
        check("ovf_set", b12.err_ovf, 1);
        check("ovf_full", b12.full, 1);
        check("ovf_depth", b12.depth_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            idle();
            b12.pop = 1;
            b12.flag_ld = (i == 0);
            b12.flag_din = 4'b0101;
            set12(i == 1, ADD, 12'hfff, 12'h001, 12'h000);
            cyc();
            check("pop_val", {b12.N, b12.Z, b12.C, b12.V}, exp_pop[i]);
        end
        idle();
        b12.pop = 1;
        cyc();
        check("unf_set", b12.err_unf, 1);
        check("unf_hold", {b12.N, b12.Z, b12.C, b12.V}, 4'b0001);
        idle();
        b12.err_clr = 1;
        cyc();
        check("clr_ovf", b12.err_ovf, 0);
        check("clr_unf", b12.err_unf, 0);

        // simultaneous push and pop at depth 2
        ld(4'b0011, 0);
        ld(4'b0101, 1);
        ld(4'b0110, 1);
        idle();
        b12.push = 1; b12.pop = 1; b12.flag_ld = 1; b12.flag_din = 4'b1001;
        cyc();
        check("pp_depth", b12.depth_cnt, 2);
        check("pp_flags", {b12.N, b12.Z, b12.C, b12.V}, 4'b1001);
        idle();
        b12.pop = 1;
        cyc();
        check("pp_top", {b12.N, b12.Z, b12.C, b12.V}, 4'b0101);
        cyc();
        check("pp_bot", {b12.N, b12.Z, b12.C, b12.V}, 4'b0011);

        // asynchronous reset between edges at depth 3
        ld(4'b0001, 1);
        ld(4'b0010, 1);
        ld(4'b0100, 1);
        idle();
        b12.push = 1;
        @(negedge clk);
        #2;
        rst = 0;
        #1;
        check_cleared("areset");
        model_reset();
        idle();
        @(posedge clk);
        #1;
        rst = 1;
        b12.pop = 1;
        cyc();
        check("areset_unf", b12.err_unf, 1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            idle();
            opc = rnd_opc();
            a = rnd_op(12); b = rnd_op(12);
            set12($urandom % 4 != 0, opc, a, b, mk_res(12, opc, a, b));
            b12.push = $urandom % 4 == 0;
            b12.pop = $urandom % 4 == 0;
            b12.flag_ld = $urandom % 6 == 0;
            b12.flag_din = 4'($urandom);
            b12.err_clr = $urandom % 8 == 0;
            opc = rnd_opc();
            a = rnd_op(8); b = rnd_op(8);
            set8($urandom % 4 != 0, opc, a, b, mk_res(8, opc, a, b));
            opc = rnd_opc();
            a = rnd_op(16); b = rnd_op(16);
            set16($urandom % 4 != 0, opc, a, b, mk_res(16, opc, a, b));
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/flags_unit.md
# flags_unit

Parametrised, registered condition-flag unit for the Complex CPU datapath; next generation of the combinational flag setter. Computes N/Z/C/V from the ALU operands and accumulator result at a configurable data width, holds them in flag registers, and adds a LIFO flag stack for interrupt/subroutine context save and restore. It sits beside the accumulator, is fed by the control unit's AC_update strobe, and drives the branch-condition logic.

## Interface
- WIDTH, 12, data width of op1/op2/AC_result (>= 2)
- DEPTH, 4, flag-stack entries (>= 1)
- OP_ADD, 4'b1001, opcode producing add-style C/V
- OP_SUB, 4'b1010, opcode producing subtract-style C/V
- OP_CMP, 4'b0100, compare; flags exactly as OP_SUB
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- AC_update  in  1  accumulator written this cycle; update flags
- opcode  in  4  current instruction opcode
- op1, op2  in  WIDTH  ALU operands (op1 - op2 for subtract)
- AC_result  in  WIDTH  ALU result
- flag_ld  in  1  load flags directly from flag_din
- flag_din  in  4  {N,Z,C,V} value for flag_ld
- push  in  1  save current flags onto stack
- pop  in  1  restore flags from stack top
- err_clr  in  1  clear sticky error bits
- N, Z, C, V  out  1 each  registered flags
- depth_cnt  out  $clog2(DEPTH+1)  entries on stack
- full, empty  out  1 each  depth_cnt == DEPTH / == 0
- err_ovf, err_unf  out  1 each  sticky push-when-full / pop-when-empty

## Operation
- Flag computation (when AC_update, opcode not flag_ld/pop overridden): N = AC_result[WIDTH-1]; Z = (AC_result == 0).
- OP_ADD: C = carry out of op1+op2 (WIDTH+1-bit sum); V = (op1[msb]==op2[msb]) & (AC_result[msb]!=op1[msb]).
- OP_SUB/OP_CMP: C = no-borrow = (op1 >= op2 unsigned); V = (op1[msb]!=op2[msb]) & (AC_result[msb]!=op1[msb]).
- Any other opcode with AC_update: N, Z updated; C, V held.
- AC_update low: all flags held.
- Flag-register write priority per cycle: pop (if not empty) > flag_ld > AC_update > hold.
- push, not full: stack[depth_cnt] <= current registered {N,Z,C,V} (pre-update value of this cycle); depth_cnt +1.
- push when full: stack unchanged, err_ovf <= 1.
- pop, not empty: {N,Z,C,V} <= stack top; depth_cnt -1; same-cycle AC_update/flag_ld discarded.
- pop when empty: flags follow flag_ld/AC_update as normal; err_unf <= 1.
- push and pop same cycle: stack and depth_cnt unchanged, no error set; flags follow flag_ld/AC_update.
- err_clr: clears both error bits; a new error in the same cycle wins (bit set).

## Timing
- All outputs registered; flag results visible the cycle after the qualifying edge (1-cycle latency).
- full/empty combinational from depth_cnt only.
- Reset (rst low, asynchronous, any time incl. mid push/pop): N=Z=C=V=0, depth_cnt=0, empty=1, full=0, err_ovf=err_unf=0; stack contents undefined, unreachable.
- Release of rst synchronised externally; first update on first rising edge with rst high.
- Back-to-back push every cycle allowed up to DEPTH; back-to-back pop allowed; push followed next cycle by pop returns the pushed value.

## Test plan
- Reset: rst low with all inputs active -> {N,Z,C,V}=0000, depth_cnt=0, empty=1, errors 0.
- Arithmetic, WIDTH=12: ADD fff+001 res 000 -> 0110; SUB 005-002 res 003 -> 0010; ADD 7ff+001 res 800 -> 1001; SUB 800-001 res 7ff -> 0011; CMP 005-002 -> 0010; opcode 0000 res 800 after 0011 -> 1011.
- Hold/priority: AC_update=0 -> flags unchanged; flag_ld din 1010 with AC_update ADD -> 1010; pop with flag_ld -> stack value.
- Stack, DEPTH=4: push 4 distinct flag sets, 5th push -> err_ovf=1, full=1, depth 4; pop 4 -> values in reverse order; 5th pop -> err_unf=1, flags unchanged; err_clr -> both 0.
- Simultaneous push+pop at depth 2 -> depth stays 2, top entry unchanged, no error.
- Async reset mid-sequence at depth 3, between clock edges -> outputs cleared immediately; subsequent pop -> err_unf=1.
- Repeat arithmetic at WIDTH=8 and WIDTH=16 with msb-boundary operands (7f+01, 80-01, 8000-0001).
